// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters.
// Fetch lookup is combinational; EX-stage resolution trains the tables and flags mispredicts.
module branch_predictor #(
    parameter int WIDTH    = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_F,
    output logic             predict_taken_F,
    output logic [WIDTH-1:0] predict_PCnext_F,
    input  logic             update_valid_E,
    input  logic [WIDTH-1:0] update_PC_E,
    input  logic             update_taken_E,
    input  logic [WIDTH-1:0] update_target_E,
    input  logic             update_is_jump_E,
    input  logic             predicted_taken_E,
    input  logic [WIDTH-1:0] predicted_target_E,
    output logic             mispredict_E,
    output logic [WIDTH-1:0] redirect_PC_E,
    output logic [WIDTH-1:0] branch_count,
    output logic [WIDTH-1:0] mispredict_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = WIDTH - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_ONE     = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_ONE;

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_ONE;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [TAG-1:0]      tag_q [ENTRIES];
    logic [TAG-1:0]      tag_d [ENTRIES];
    logic [WIDTH-1:0]    tgt_q [ENTRIES];
    logic [WIDTH-1:0]    tgt_d [ENTRIES];
    logic [WIDTH-1:0]    branch_count_q, branch_count_d;
    logic [WIDTH-1:0]    mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0] f_idx, u_idx;
    logic [TAG-1:0] f_tag, u_tag;
    logic           f_hit, u_hit;

    assign f_idx = PC_F[IDX+1:2];
    assign f_tag = PC_F[WIDTH-1:IDX+2];
    assign u_idx = update_PC_E[IDX+1:2];
    assign u_tag = update_PC_E[WIDTH-1:IDX+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign predict_taken_F  = f_hit && ctr_q[f_idx][CTR_BITS-1];
    assign predict_PCnext_F = predict_taken_F ? tgt_q[f_idx] : PC_F + WIDTH'(4);

    assign mispredict_E  = update_valid_E &&
                           ((predicted_taken_E != update_taken_E) ||
                            (update_taken_E && (predicted_target_E != update_target_E)));
    assign redirect_PC_E = update_taken_E ? update_target_E : update_PC_E + WIDTH'(4);

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    always_comb begin
        valid_d            = valid_q;
        ctr_d              = ctr_q;
        tag_d              = tag_q;
        tgt_d              = tgt_q;
        branch_count_d     = branch_count_q + (update_valid_E ? WIDTH'(1) : WIDTH'(0));
        mispredict_count_d = mispredict_count_q + (mispredict_E ? WIDTH'(1) : WIDTH'(0));
        if (update_valid_E) begin
            if (u_hit) begin
                if (update_is_jump_E) begin
                    ctr_d[u_idx] = CTR_MAX;
                    tgt_d[u_idx] = update_target_E;
                end else begin
                    ctr_d[u_idx] = update_taken_E ? sat_inc(ctr_q[u_idx]) : sat_dec(ctr_q[u_idx]);
                    if (update_taken_E) begin
                        tgt_d[u_idx] = update_target_E;
                    end
                end
            end else if (update_taken_E) begin
                // Allocation replaces whatever aliased into this slot.
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = update_target_E;
                ctr_d[u_idx]   = update_is_jump_E ? CTR_MAX : CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else begin
            valid_q            <= valid_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (WIDTH=32, ENTRIES=16, CTR_BITS=2).
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] PC_F;
    logic        predict_taken_F;
    logic [31:0] predict_PCnext_F;
    logic        update_valid_E;
    logic [31:0] update_PC_E;
    logic        update_taken_E;
    logic [31:0] update_target_E;
    logic        update_is_jump_E;
    logic        predicted_taken_E;
    logic [31:0] predicted_target_E;
    logic        mispredict_E;
    logic [31:0] redirect_PC_E;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .CTR_BITS(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .PC_F              (PC_F),
        .predict_taken_F   (predict_taken_F),
        .predict_PCnext_F  (predict_PCnext_F),
        .update_valid_E    (update_valid_E),
        .update_PC_E       (update_PC_E),
        .update_taken_E    (update_taken_E),
        .update_target_E   (update_target_E),
        .update_is_jump_E  (update_is_jump_E),
        .predicted_taken_E (predicted_taken_E),
        .predicted_target_E(predicted_target_E),
        .mispredict_E      (mispredict_E),
        .redirect_PC_E     (redirect_PC_E),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc);
        PC_F = pc;
        #1;
        check({tag, "_taken"}, 32'(predict_taken_F), 32'(exp_t));
        check({tag, "_next"}, predict_PCnext_F, exp_pc);
    endtask

    task automatic counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        check({tag, "_bc"}, branch_count, bc);
        check({tag, "_mc"}, mispredict_count, mc);
    endtask

    // Present one resolving branch, check the EX outputs, then commit it on the next edge.
    task automatic upd(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic jmp, input logic ptk, input logic [31:0] ptgt,
                       input logic exp_m, input logic [31:0] exp_r);
        update_valid_E     = 1'b1;
        update_PC_E        = pc;
        update_taken_E     = tk;
        update_target_E    = tgt;
        update_is_jump_E   = jmp;
        predicted_taken_E  = ptk;
        predicted_target_E = ptgt;
        #1;
        check({tag, "_misp"}, 32'(mispredict_E), 32'(exp_m));
        if (exp_m) check({tag, "_redir"}, redirect_PC_E, exp_r);
        tick();
        update_valid_E = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        PC_F = 32'h100;
        update_valid_E = 1'b0;
        update_PC_E = '0;
        update_taken_E = 1'b0;
        update_target_E = '0;
        update_is_jump_E = 1'b0;
        predicted_taken_E = 1'b0;
        predicted_target_E = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and +4 wrap at the top of the address space
        lookup("reset", 32'h100, 1'b0, 32'h104);
        counts("reset", 0, 0);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Cold taken branch allocates weakly taken
        upd("cold", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        counts("cold", 1, 1);
        lookup("cold", 32'h100, 1'b1, 32'h80);

        // Training down, then up to saturation
        upd("nt1", 32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104);
        lookup("nt1", 32'h100, 1'b0, 32'h104);
        upd("nt2", 32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0);
        counts("nt2", 3, 2);
        upd("t1", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup("t1", 32'h100, 1'b0, 32'h104);
        upd("t2", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup("t2", 32'h100, 1'b1, 32'h80);
        upd("t3", 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        upd("t4", 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        upd("nt3", 32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104);
        lookup("sat", 32'h100, 1'b1, 32'h80);
        counts("train", 8, 5);

        // Aliasing: 0x140 shares index 0 with 0x100
        lookup("alias_miss", 32'h140, 1'b0, 32'h144);
        upd("alias", 32'h140, 1'b1, 32'h20, 1'b0, 1'b0, 32'h144, 1'b1, 32'h20);
        lookup("alias_new", 32'h140, 1'b1, 32'h20);
        lookup("alias_old", 32'h100, 1'b0, 32'h104);

        // JALR retarget
        upd("jalr1", 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h204, 1'b1, 32'h300);
        lookup("jalr1", 32'h200, 1'b1, 32'h300);
        upd("jalr2", 32'h200, 1'b1, 32'h400, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400);
        lookup("jalr2", 32'h200, 1'b1, 32'h400);
        counts("jalr", 11, 8);

        // Same-cycle lookup and update of one index
        upd("realloc", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        PC_F = 32'h100;
        update_valid_E     = 1'b1;
        update_PC_E        = 32'h100;
        update_taken_E     = 1'b0;
        update_is_jump_E   = 1'b0;
        predicted_taken_E  = 1'b1;
        predicted_target_E = 32'h80;
        #1;
        check("same_old_taken", 32'(predict_taken_F), 32'd1);
        check("same_old_next", predict_PCnext_F, 32'h80);
        check("same_misp", 32'(mispredict_E), 32'd1);
        check("same_redir", redirect_PC_E, 32'h104);
        tick();
        update_valid_E = 1'b0;
        lookup("same_new", 32'h100, 1'b0, 32'h104);
        counts("same", 13, 10);

        // Asynchronous reset between edges
        upd("pre_rst", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup("pre_rst", 32'h100, 1'b1, 32'h80);
        counts("pre_rst", 14, 11);
        #1;
        rst = 1'b1;
        #1;
        check("arst_taken", 32'(predict_taken_F), 32'd0);
        check("arst_next", predict_PCnext_F, 32'h104);
        counts("arst", 0, 0);
        update_valid_E     = 1'b1;
        update_PC_E        = 32'h500;
        update_taken_E     = 1'b0;
        predicted_taken_E  = 1'b1;
        #1;
        check("arst_misp", 32'(mispredict_E), 32'd1);
        check("arst_redir", redirect_PC_E, 32'h504);
        update_valid_E = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        lookup("post_rst", 32'h100, 1'b0, 32'h104);
        counts("post_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
